// File: rtl/switch_input_ctrl.sv
// Switch-side IO peripheral: two-flop sync, prescaled per-bit debounce, sticky
// change flags with clear-on-read, and a registered 16-bit read port.
module switch_input_ctrl #(
  parameter int SW_WIDTH = 24,
  parameter int TICK_DIV = 100000,
  parameter int DB_COUNT = 4
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                SwitchCtrl,
  input  logic                ioRead,
  input  logic [3:0]          addr_low,
  output logic [15:0]         io_rdata,
  output logic [SW_WIDTH-1:0] sw_stable
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [SW_WIDTH-1:0] LO_MASK = SW_WIDTH'(32'h0000_FFFF);

  logic [SW_WIDTH-1:0] sync1, sync2;
  logic [SW_WIDTH-1:0] chg, chg_set, chg_clr, stable_nxt;
  logic [PRE_W-1:0]    pre_cnt;
  logic [CNT_W-1:0]    db_cnt     [SW_WIDTH];
  logic [CNT_W-1:0]    db_cnt_nxt [SW_WIDTH];
  logic [31:0]         stable_ext, chg_ext;
  logic [15:0]         rd_word;
  logic                tick, rd_sel;

  assign tick       = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign rd_sel     = SwitchCtrl & ioRead;
  // Widen to 32 bits so the upper bank pads with zeros for any SW_WIDTH.
  assign stable_ext = 32'(sw_stable);
  assign chg_ext    = 32'(chg);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    stable_nxt = sw_stable;
    chg_set    = '0;
    db_cnt_nxt = db_cnt;
    if (tick) begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          db_cnt_nxt[i] = '0;
        end else if (db_cnt[i] == CNT_W'(DB_COUNT - 1)) begin
          stable_nxt[i] = sync2[i];
          db_cnt_nxt[i] = '0;
          chg_set[i]    = 1'b1;
        end else begin
          // NOTE: blocking '=' here because this is combinational; flops below use '<=' only.
          db_cnt_nxt[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Read mux sees pre-edge state; the clear mask only fires on a qualified read.
  always_comb begin
    rd_word = 16'h0000;
    chg_clr = '0;
    case (addr_low)
      4'h0: rd_word = stable_ext[15:0];
      4'h2: rd_word = stable_ext[31:16];
      4'h4: begin
        rd_word = chg_ext[15:0];
        if (rd_sel) chg_clr = LO_MASK;
      end
      4'h6: begin
        rd_word = chg_ext[31:16];
        if (rd_sel) chg_clr = ~LO_MASK;
      end
      default: rd_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      pre_cnt   <= '0;
      sw_stable <= '0;
      chg       <= '0;
      io_rdata  <= 16'h0000;
      // NOTE: the counter array is reset explicitly; a reset mid-debounce must discard partial counts.
      for (int i = 0; i < SW_WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= sw_raw;
      sync2     <= sync1;
      pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
      sw_stable <= stable_nxt;
      db_cnt    <= db_cnt_nxt;
      // Set is applied after clear so a same-edge debounce update wins.
      chg       <= (chg & ~chg_clr) | chg_set;
      if (rd_sel) io_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with TICK_DIV=4, DB_COUNT=3, SW_WIDTH=24.
module tb_switch_input_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [23:0] sw_raw;
  logic        SwitchCtrl, ioRead;
  logic [3:0]  addr_low;
  logic [15:0] io_rdata;
  logic [23:0] sw_stable;

  int n_vec = 0;
  int n_err = 0;

  switch_input_ctrl #(.SW_WIDTH(24), .TICK_DIV(4), .DB_COUNT(3)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .SwitchCtrl (SwitchCtrl),
    .ioRead     (ioRead),
    .addr_low   (addr_low),
    .io_rdata   (io_rdata),
    .sw_stable  (sw_stable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then park on the falling edge where outputs are sampled.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string tag);
    SwitchCtrl = 1'b1;
    ioRead     = 1'b1;
    addr_low   = a;
    step(1);
    SwitchCtrl = 1'b0;
    ioRead     = 1'b0;
    check(tag, 32'(io_rdata), 32'(exp));
  endtask

  task automatic wait_stable(input logic [23:0] exp, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (sw_stable == exp) break;
    end
    check(tag, 32'(sw_stable), 32'(exp));
  endtask

  initial begin
    SwitchCtrl = 1'b0;
    ioRead     = 1'b0;
    addr_low   = 4'h0;
    rst_n      = 1'b0;
    sw_raw     = 24'hFFFFFF;
    @(negedge clock);
    step(5);
    check("rst_rdata", 32'(io_rdata), 32'h0);
    check("rst_stable", 32'(sw_stable), 32'h0);
    rst_n  = 1'b1;
    sw_raw = 24'h000000;
    do_read(4'h4, 16'h0000, "rst_chg_lo");
    do_read(4'h6, 16'h0000, "rst_chg_hi");

    // Debounce of a lower-bank pattern, reads and clear-on-read
    sw_raw = 24'h00A5A5;
    wait_stable(24'h00A5A5, 2 + 3 * 4, "db_settle");
    do_read(4'h0, 16'hA5A5, "rd_stable_lo");
    SwitchCtrl = 1'b1;
    ioRead     = 1'b0;
    addr_low   = 4'h4;
    step(1);
    SwitchCtrl = 1'b0;
    check("no_capture", 32'(io_rdata), 32'h0000A5A5);
    do_read(4'h4, 16'hA5A5, "rd_chg_lo");
    do_read(4'h4, 16'h0000, "rd_chg_lo_clr");
    do_read(4'h6, 16'h0000, "rd_chg_hi_none");

    // Glitch of 6 clocks (< 3 ticks) on a bit that is stable low
    sw_raw[1] = 1'b1;
    step(6);
    sw_raw[1] = 1'b0;
    step(20);
    check("glitch_stable", 32'(sw_stable), 32'h0000A5A5);
    do_read(4'h4, 16'h0000, "glitch_chg");

    // Upper bank, unmapped address, upper change flags
    sw_raw = 24'h5A0000;
    wait_stable(24'h5A0000, 2 + 3 * 4, "upper_settle");
    do_read(4'h2, 16'h005A, "rd_upper");
    do_read(4'h9, 16'h0000, "rd_unmapped");
    do_read(4'h6, 16'h005A, "rd_chg_hi");
    do_read(4'h6, 16'h0000, "rd_chg_hi_clr");
    do_read(4'h4, 16'hA5A5, "rd_chg_lo_fall");

    // Set-vs-clear: keep reading 0x4 every cycle until bit 3 is accepted
    sw_raw     = 24'h5A0008;
    SwitchCtrl = 1'b1;
    ioRead     = 1'b1;
    addr_low   = 4'h4;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sw_stable[3]) break;
    end
    SwitchCtrl = 1'b0;
    ioRead     = 1'b0;
    check("sc_stable", 32'(sw_stable), 32'h005A0008);
    check("sc_returned", 32'(io_rdata), 32'h0);
    do_read(4'h4, 16'h0008, "sc_chg_kept");

    // Reset mid-debounce: 2 ticks counted, then reset, then a full 3 ticks again
    rst_n  = 1'b0;
    sw_raw = 24'h000000;
    step(5);
    check("md_rst_stable", 32'(sw_stable), 32'h0);
    rst_n  = 1'b1;
    sw_raw = 24'h000010;
    step(9);
    check("md_partial", 32'(sw_stable), 32'h0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(11);
    check("md_after_11", 32'(sw_stable), 32'h0);
    step(1);
    check("md_after_12", 32'(sw_stable), 32'h000010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
